cdb_arbiter: RTL and testbench

//  Common-data-bus arbiter for the Tomasulo core. It shares the single CDB between

---
 rtl/cdb_arbiter_if.sv | 25 ++
 rtl/cdb_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester/broadcast bundle between functional units and the CDB arbiter
interface cdb_arbiter_if #(
    parameter int N_REQ  = 7,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [15:0]             bcast_cnt;

    modport master (
        output req, req_tag, req_data,
        input  gnt, cdb_valid, cdb_tag, cdb_data, bcast_cnt
    );

    modport slave (
        input  req, req_tag, req_data,
        output gnt, cdb_valid, cdb_tag, cdb_data, bcast_cnt
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with registered broadcast
// Optional: CDB_LOAD_PRIO_EN gives the load unit (index N_REQ-1) absolute priority.
module cdb_arbiter #(
    parameter int N_REQ  = 7,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic         clk1,
    input  logic         rst_n,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  gnt_c;
    logic [PTR_W-1:0]  win_idx;
    logic              any_gnt;
    logic              load_prio_win;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic [PTR_W:0]    scan_sum;
    logic [PTR_W-1:0]  scan_idx;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [15:0]       bcast_cnt_q;

    // Scan upward from rr_ptr with wrap; the first requester found wins.
    always_comb begin
        gnt_c         = '0;
        win_idx       = '0;
        any_gnt       = 1'b0;
        load_prio_win = 1'b0;
        scan_sum      = '0;
        scan_idx      = '0;
        if (rst_n && !flush) begin
`ifdef CDB_LOAD_PRIO_EN
            if (bus.req[N_REQ-1]) begin
                gnt_c[N_REQ-1] = 1'b1;
                win_idx        = LAST_IDX;
                any_gnt        = 1'b1;
                load_prio_win  = 1'b1;
            end
`endif
            for (int k = 0; k < N_REQ; k++) begin
                scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (scan_sum >= N_EXT) begin
                    scan_sum = scan_sum - N_EXT;
                end
                scan_idx = scan_sum[PTR_W-1:0];
                if (!any_gnt && bus.req[scan_idx]) begin
                    gnt_c[scan_idx] = 1'b1;
                    win_idx         = scan_idx;
                    any_gnt         = 1'b1;
                end
            end
        end
    end

    // Grant is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_c[i]) begin
                win_tag  = win_tag  | bus.req_tag[i*TAG_W +: TAG_W];
                win_data = win_data | bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            bcast_cnt_q <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
            rr_ptr      <= '0;
        end else if (any_gnt) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= win_tag;
            cdb_data_q  <= win_data;
            bcast_cnt_q <= bcast_cnt_q + 16'd1;
            // A priority load grant leaves the rotation where it was.
            if (!load_prio_win) begin
                rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
            end
        end else begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.bcast_cnt = bcast_cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter against a behavioural model
module tb_cdb_arbiter;
    localparam int N  = 7;
    localparam int TW = 3;
    localparam int DW = 32;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic [N-1:0]  req_v = '0;
    logic [TW-1:0] r_tag  [N];
    logic [DW-1:0] r_data [N];

    cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk1 = ~clk1;

    assign bus.req = req_v;
    always_comb begin
        bus.req_tag  = '0;
        bus.req_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_tag[i*TW +: TW]  = r_tag[i];
            bus.req_data[i*DW +: DW] = r_data[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a rotating priority list, plus the broadcast registers.
    int          m_ptr    = 0;
    bit          m_valid  = 1'b0;
    logic [TW-1:0] m_tag  = '0;
    logic [DW-1:0] m_data = '0;
    int          m_cnt    = 0;
    int          m_last_w = -1;

    function automatic int pick(input logic [N-1:0] r, input logic fl, input int ptr);
        if (fl) return -1;
`ifdef CDB_LOAD_PRIO_EN
        if (r[N-1]) return N-1;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] e;
        e = '0;
        if (w >= 0) e[w] = 1'b1;
        return e;
    endfunction

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_cnt = 0; m_last_w = -1;
        end else begin
            m_last_w = pick(req_v, flush, m_ptr);
            if (flush) begin
                m_valid = 1'b0;
                m_ptr   = 0;
            end else if (m_last_w >= 0) begin
                m_valid = 1'b1;
                m_tag   = r_tag[m_last_w];
                m_data  = r_data[m_last_w];
                m_cnt   = (m_cnt + 1) % 65536;
`ifdef CDB_LOAD_PRIO_EN
                if (m_last_w != N-1) m_ptr = (m_last_w + 1) % N;
`else
                m_ptr = (m_last_w + 1) % N;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk1) begin
        if (rst_n) begin
            chk("model_gnt",       32'(bus.gnt),       32'(onehot(pick(req_v, flush, m_ptr))));
            chk("model_cdb_valid", 32'(bus.cdb_valid), 32'(m_valid));
            chk("model_cdb_tag",   32'(bus.cdb_tag),   32'(m_tag));
            chk("model_cdb_data",  bus.cdb_data,       m_data);
            chk("model_bcast_cnt", 32'(bus.bcast_cnt), 32'(m_cnt));
        end
    end

    task automatic clear_ptr();
        req_v = '0;
        flush = 1'b1;
        @(posedge clk1); #1;
        flush = 1'b0;
    endtask

    logic [N-1:0] e3 [8];

    initial begin
        for (int i = 0; i < N; i++) begin
            r_tag[i]  = TW'(i);
            r_data[i] = 32'(100 + i);
        end
        // 1 reset with every unit requesting
        #1 rst_n = 1'b0;
        req_v = 7'h7F;
        @(negedge clk1);
        chk("t1_reset_gnt",   32'(bus.gnt),       32'h0);
        chk("t1_reset_valid", 32'(bus.cdb_valid), 32'h0);
        chk("t1_reset_cnt",   32'(bus.bcast_cnt), 32'h0);
        @(posedge clk1); #1 rst_n = 1'b1;
        @(negedge clk1);
`ifdef CDB_LOAD_PRIO_EN
        chk("t1_first_gnt", 32'(bus.gnt), 32'h40);
`else
        chk("t1_first_gnt", 32'(bus.gnt), 32'h01);
`endif
        @(posedge clk1); #1;
        clear_ptr();

        // 2 single requester granted every cycle
        r_tag[3]  = 3'd5;
        r_data[3] = 32'd42;
        req_v = 7'h08;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk1);
            if (c <= 3) chk("t2_gnt", 32'(bus.gnt), 32'h08);
            if (c >= 2) begin
                chk("t2_valid", 32'(bus.cdb_valid), 32'h1);
                chk("t2_tag",   32'(bus.cdb_tag),   32'd5);
                chk("t2_data",  bus.cdb_data,       32'd42);
            end
            if (c == 4) chk("t2_cnt", 32'(bus.bcast_cnt), 32'd4);
            @(posedge clk1); #1;
            if (c == 3) req_v = '0;
        end
        clear_ptr();

        // 3 full rotation
`ifdef CDB_LOAD_PRIO_EN
        e3 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`else
        e3 = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01};
`endif
        req_v = 7'h7F;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk1);
            chk("t3_rotation", 32'(bus.gnt), 32'(e3[c]));
            @(posedge clk1); #1;
        end
        clear_ptr();

        // 4 pointer wrap from the last requester
        req_v = 7'h20;
        @(posedge clk1); #1;
        req_v = 7'h41;
        @(negedge clk1);
        chk("t4_wrap_a", 32'(bus.gnt), 32'h40);
        @(posedge clk1); #1;
        @(negedge clk1);
`ifdef CDB_LOAD_PRIO_EN
        chk("t4_wrap_b", 32'(bus.gnt), 32'h40);
`else
        chk("t4_wrap_b", 32'(bus.gnt), 32'h01);
`endif
        @(posedge clk1); #1;
        clear_ptr();

        // 5 flush resets the pointer and suppresses the grant
        req_v = 7'h01;
        @(posedge clk1); #1;
        req_v = 7'h03;
        flush = 1'b1;
        @(negedge clk1);
        chk("t5_flush_gnt", 32'(bus.gnt), 32'h0);
        @(posedge clk1); #1 flush = 1'b0;
        @(negedge clk1);
        chk("t5_valid_after", 32'(bus.cdb_valid), 32'h0);
        chk("t5_gnt_after",   32'(bus.gnt),       32'h01);
        @(posedge clk1); #1;
        clear_ptr();

        // 6 load priority behaviour
        req_v = 7'h7F;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk1);
`ifdef CDB_LOAD_PRIO_EN
            chk("t6_load", 32'(bus.gnt), 32'h40);
`else
            chk("t6_load", 32'(bus.gnt), 32'(1 << c));
`endif
            @(posedge clk1); #1;
        end
        req_v = 7'h3F;
        @(negedge clk1);
`ifdef CDB_LOAD_PRIO_EN
        chk("t6_resume", 32'(bus.gnt), 32'h01);
`else
        chk("t6_resume", 32'(bus.gnt), 32'h08);
`endif
        @(posedge clk1); #1;
        clear_ptr();

        // async reset while a broadcast is on the bus
        req_v = 7'h7F;
        @(posedge clk1); #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.cdb_valid), 32'h0);
        chk("async_gnt",   32'(bus.gnt),       32'h0);
        chk("async_cnt",   32'(bus.bcast_cnt), 32'h0);
        @(posedge clk1); #1 rst_n = 1'b1;

        // randomized traffic obeying the hold-until-granted handshake
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk1); #1;
            for (int i = 0; i < N; i++) begin
                if (req_v[i] && m_last_w == i) begin
                    req_v[i]  = ($urandom_range(0, 3) != 0);
                    r_tag[i]  = TW'($urandom);
                    r_data[i] = $urandom;
                end else if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_v[i]  = 1'b1;
                    r_tag[i]  = TW'($urandom);
                    r_data[i] = $urandom;
                end
            end
            flush = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk1); #1 flush = 1'b0;
        @(negedge clk1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
